// File: rtl/i2s_target.sv
// I2S target endpoint: all logic on mclk, with sclk/lrck/sdi oversampled.
// It deserialises sdi into stereo frames and serialises stereo frames onto sdo.
package sample_pkg;
    typedef struct packed {
        logic [23:0] lc;
        logic [23:0] rc;
    } sample_t;
endpackage

module i2s_target
    import sample_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_SLOT    = 24,
    parameter int unsigned MAX_SLOT    = 32
) (
    input  logic    mclk,
    input  logic    rst_n,
    input  logic    sclk,
    input  logic    lrck,
    input  logic    sdi,
    output logic    sdo,
    output sample_t rx_data,
    output logic    rx_vld,
    input  sample_t tx_data,
    input  logic    tx_vld,
    output logic    frame_err,
    output logic    tx_urun
);

    localparam int unsigned CW = $clog2(MAX_SLOT + 2);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_SLOT + 1);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_SLOT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_SLOT);
    localparam logic [CW-1:0] CNT_WORD = CW'(24);

    typedef enum logic [0:0] {StSync, StRun} state_t;

    // Synchronisers are left unreset so a reset never creates a false sclk edge.
    logic [SYNC_STAGES-1:0] sclk_sync, lrck_sync, sdi_sync;
    logic                   sclk_prev;

    always_ff @(posedge mclk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
        sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    logic sclk_s, ws_now, bit_s, rise, fall;
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ws_now = lrck_sync[SYNC_STAGES-1];
    assign bit_s  = sdi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    state_t          state_q;
    logic            ws_prev_q;
    logic [CW-1:0]   cnt_l_q, cnt_r_q;
    logic [23:0]     word_l_q, word_r_q;
    logic            ok_l_q;
    sample_t         hold_q, frame_q;
    logic            pend_q;
    logic [4:0]      tx_idx_q;
    logic            tx_ch_q;

    logic            ch_end, frame_start, slot_ok, sdo_next;
    logic [CW-1:0]   cnt_cur, cnt_inc;
    logic [23:0]     word_cur, word_inc, tx_word;

    always_comb begin
        ch_end      = (ws_now != ws_prev_q);
        frame_start = ws_prev_q & ~ws_now;
        cnt_cur     = ws_prev_q ? cnt_r_q : cnt_l_q;
        cnt_inc     = (cnt_cur == CNT_SAT) ? cnt_cur : cnt_cur + CW'(1);
        slot_ok     = (cnt_inc >= CNT_MIN) && (cnt_inc <= CNT_MAX);
        word_cur    = ws_prev_q ? word_r_q : word_l_q;
        word_inc    = (cnt_cur < CNT_WORD) ? {word_cur[22:0], bit_s} : word_cur;
        tx_word     = tx_ch_q ? frame_q.rc : frame_q.lc;
        sdo_next    = 1'b0;
        if (tx_idx_q < 5'd24) begin
            sdo_next = tx_word[5'd23 - tx_idx_q];
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q   <= StSync;
            ws_prev_q <= 1'b0;
            cnt_l_q   <= '0;
            cnt_r_q   <= '0;
            word_l_q  <= '0;
            word_r_q  <= '0;
            ok_l_q    <= 1'b0;
            rx_data   <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            tx_urun   <= 1'b0;
            hold_q    <= '0;
            frame_q   <= '0;
            pend_q    <= 1'b0;
            tx_idx_q  <= '0;
            tx_ch_q   <= 1'b0;
            sdo       <= 1'b0;
        end else begin
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            tx_urun   <= 1'b0;
            if (tx_vld) begin
                hold_q <= tx_data;
                pend_q <= 1'b1;
            end
            if (rise) begin
                ws_prev_q <= ws_now;
                if (ch_end) begin
                    tx_idx_q <= '0;
                    tx_ch_q  <= ws_now;
                end
                unique case (state_q)
                    StSync: begin
                        if (frame_start) begin
                            state_q <= StRun;
                            cnt_l_q <= '0;
                            cnt_r_q <= '0;
                            ok_l_q  <= 1'b0;
                        end
                    end
                    StRun: begin
                        if (ws_prev_q) word_r_q <= word_inc;
                        else           word_l_q <= word_inc;
                        if (ch_end) begin
                            cnt_l_q <= '0;
                            cnt_r_q <= '0;
                            if (!ws_prev_q) begin
                                ok_l_q <= slot_ok;
                            end else begin
                                // Right-channel end closes the frame.
                                ok_l_q <= 1'b0;
                                if (ok_l_q && slot_ok) begin
                                    rx_data <= '{lc: word_l_q, rc: word_inc};
                                    rx_vld  <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end else if (ws_prev_q) begin
                            cnt_r_q <= cnt_inc;
                        end else begin
                            cnt_l_q <= cnt_inc;
                        end
                        if (frame_start) begin
                            if (tx_vld) begin
                                frame_q <= tx_data;
                                pend_q  <= 1'b0;
                            end else if (pend_q) begin
                                frame_q <= hold_q;
                                pend_q  <= 1'b0;
                            end else begin
                                tx_urun <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StSync;
                endcase
            end
            if (fall) begin
                if (state_q == StRun) begin
                    sdo <= sdo_next;
                    if (tx_idx_q != 5'd24) tx_idx_q <= tx_idx_q + 5'd1;
                end else begin
                    sdo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_target.sv
// Bench for i2s_target: a master model drives one frame per table record and checks
// pulses, rx_data and the sdo bit stream against hand-computed values.
module tb_i2s_target;
    import sample_pkg::*;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic    mclk = 1'b0;
    logic    rst_n = 1'b0;
    logic    sclk = 1'b0;
    logic    lrck = 1'b0;
    logic    sdi = 1'b0;
    logic    tx_vld = 1'b0;
    sample_t tx_data = '0;
    logic    sdo, rx_vld, frame_err, tx_urun;
    sample_t rx_data;

    i2s_target #(
        .SYNC_STAGES(SYNC),
        .MIN_SLOT   (24),
        .MAX_SLOT   (32)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .lrck     (lrck),
        .sdi      (sdi),
        .sdo      (sdo),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .frame_err(frame_err),
        .tx_urun  (tx_urun)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;
    int n_vld = 0;
    int n_err = 0;
    int n_urun = 0;
    int n_both = 0;

    always @(negedge mclk) begin
        if (rx_vld) n_vld++;
        if (frame_err) n_err++;
        if (tx_urun) n_urun++;
        if (rx_vld && frame_err) n_both++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // txv: 0 none, 1 strobe early in the frame, 2 strobe on the frame-start mclk.
    typedef struct {
        int          slot;
        logic [23:0] lc, rc;
        int          txv;
        logic [23:0] tlc, trc;
        int          rst_pos;
        int          e_vld, e_err, e_urun;
        logic [47:0] e_rx;
        bit          chk_sdo;
        logic [23:0] slc, src;
    } vec_t;

    vec_t vecs[12];

    task automatic strobe_tx(input logic [23:0] l, input logic [23:0] r);
        tx_data = '{lc: l, rc: r};
        tx_vld  = 1'b1;
        @(negedge mclk);
        tx_vld  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic [63:0] got = '0;
        logic [63:0] exp = '0;
        int v0 = n_vld;
        int e0 = n_err;
        int u0 = n_urun;
        for (int p = 0; p < 2 * v.slot; p++) begin
            int c = (p < v.slot) ? 0 : 1;
            int b = p - c * v.slot;
            int cn = (p + 1 < v.slot || p + 1 == 2 * v.slot) ? 0 : 1;
            logic [23:0] w = (c == 1) ? v.rc : v.lc;
            logic [23:0] sw = (c == 1) ? v.src : v.slc;
            sclk = 1'b0;
            lrck = cn[0];
            sdi  = (b < 24) ? w[23-b] : 1'b0;
            exp[p] = (b < 24) ? sw[23-b] : 1'b0;
            if (p == v.rst_pos) begin
                rst_n = 1'b0;
                repeat (3) @(negedge mclk);
                check($sformatf("frame%0d reset outputs", idx),
                      {11'd0, rx_data, rx_vld, sdo, frame_err, tx_urun}, 64'd0);
                rst_n = 1'b1;
            end
            if (v.txv == 1 && p == 2) strobe_tx(v.tlc, v.trc);
            repeat (HALF) @(negedge mclk);
            got[p] = sdo;
            sclk = 1'b1;
            // The DUT acts on a rising edge SYNC_STAGES+1 mclk after sclk rises.
            if (v.txv == 2 && p == 2 * v.slot - 1) begin
                repeat (SYNC) @(negedge mclk);
                strobe_tx(v.tlc, v.trc);
            end
            repeat (HALF) @(negedge mclk);
        end
        check($sformatf("frame%0d rx_vld count", idx), 64'(n_vld - v0), 64'(v.e_vld));
        check($sformatf("frame%0d frame_err count", idx), 64'(n_err - e0), 64'(v.e_err));
        check($sformatf("frame%0d tx_urun count", idx), 64'(n_urun - u0), 64'(v.e_urun));
        check($sformatf("frame%0d rx_data", idx), 64'(rx_data), 64'(v.e_rx));
        if (v.chk_sdo) check($sformatf("frame%0d sdo stream", idx), got, exp);
    endtask

    initial begin
        //          slot lc          rc          txv tlc         trc         rst vld err urun e_rx                sdo   slc         src
        vecs[0]  = '{32, 24'hA5A5A5, 24'h5A5A5A, 1, 24'h800001, 24'h123456, -1, 0, 0, 0, 48'h0,              1'b1, 24'h000000, 24'h000000};
        vecs[1]  = '{32, 24'hA5A5A5, 24'h5A5A5A, 0, 24'h0,      24'h0,      -1, 1, 0, 0, 48'hA5A5A5_5A5A5A,  1'b1, 24'h000000, 24'h000000};
        vecs[2]  = '{32, 24'hA5A5A5, 24'h5A5A5A, 0, 24'h0,      24'h0,      -1, 1, 0, 1, 48'hA5A5A5_5A5A5A,  1'b1, 24'h800001, 24'h123456};
        vecs[3]  = '{32, 24'hA5A5A5, 24'h5A5A5A, 0, 24'h0,      24'h0,      -1, 1, 0, 1, 48'hA5A5A5_5A5A5A,  1'b1, 24'h800001, 24'h123456};
        vecs[4]  = '{24, 24'h123456, 24'hABCDEF, 1, 24'hC0FFEE, 24'h0F0F0F, -1, 1, 0, 0, 48'h123456_ABCDEF,  1'b1, 24'h800001, 24'h123456};
        vecs[5]  = '{20, 24'h111111, 24'h222222, 0, 24'h0,      24'h0,      -1, 0, 1, 1, 48'h123456_ABCDEF,  1'b1, 24'hC0FFEE, 24'h0F0F0F};
        vecs[6]  = '{20, 24'h333333, 24'h444444, 0, 24'h0,      24'h0,      -1, 0, 1, 1, 48'h123456_ABCDEF,  1'b1, 24'hC0FFEE, 24'h0F0F0F};
        vecs[7]  = '{32, 24'hA5A5A5, 24'h5A5A5A, 0, 24'h0,      24'h0,      -1, 1, 0, 1, 48'hA5A5A5_5A5A5A,  1'b1, 24'hC0FFEE, 24'h0F0F0F};
        vecs[8]  = '{32, 24'h000001, 24'h800000, 2, 24'h13579B, 24'h2468AC, -1, 1, 0, 0, 48'h000001_800000,  1'b1, 24'hC0FFEE, 24'h0F0F0F};
        vecs[9]  = '{32, 24'hFFFFFF, 24'h000000, 0, 24'h0,      24'h0,      -1, 1, 0, 1, 48'hFFFFFF_000000,  1'b1, 24'h13579B, 24'h2468AC};
        vecs[10] = '{32, 24'h111111, 24'h222222, 0, 24'h0,      24'h0,      42, 0, 0, 0, 48'h0,              1'b0, 24'h000000, 24'h000000};
        vecs[11] = '{32, 24'hFEDCBA, 24'h012345, 0, 24'h0,      24'h0,      -1, 1, 0, 1, 48'hFEDCBA_012345,  1'b1, 24'h000000, 24'h000000};

        repeat (4) @(negedge mclk);
        check("initial reset outputs", {11'd0, rx_data, rx_vld, sdo, frame_err, tx_urun}, 64'd0);
        rst_n = 1'b1;
        @(negedge mclk);
        for (int i = 0; i < 12; i++) run_frame(vecs[i], i);
        check("rx_vld with frame_err overlap", 64'(n_both), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
